// File: rtl/acb_arbiter.sv
// rtl/acb_arbiter.sv - round-robin scheduler sharing one acb GF(2^163) unit among NUM_REQ requesters
// Optional watchdog abort enabled by defining ACB_ARB_TIMEOUT_EN.
module acb_arbiter #(
    parameter int WIDTH   = 163,
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 512
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ-1:0]       req_op,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    output logic [NUM_REQ-1:0]       gnt,
    output logic [WIDTH-1:0]         res,
    output logic [NUM_REQ-1:0]       res_valid,
    output logic                     res_err,
    output logic                     busy,
    output logic                     acb_rst,
    output logic                     acb_enable,
    output logic                     acb_configuration,
    output logic [WIDTH-1:0]         acb_a,
    output logic [WIDTH-1:0]         acb_b,
    input  logic [WIDTH-1:0]         acb_c,
    input  logic                     acb_done
);
    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int ID_W1 = ID_W + 1;
    localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT < 1) begin : g_param_check
        $error("acb_arbiter: unsupported parameters");
    end

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t          state;
    logic [ID_W-1:0] ptr;
    logic [ID_W-1:0] id;
    logic [ID_W-1:0] sel_id;
    logic [ID_W1-1:0] scan_idx;
    logic            sel_found;
    logic            done_q;
    logic            done_rise;

    // Scan downward so the requester closest to ptr (in wrap order) overwrites the others.
    always_comb begin
        sel_id    = '0;
        sel_found = 1'b0;
        scan_idx  = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            scan_idx = {1'b0, ptr} + ID_W1'(k);
            if (scan_idx >= ID_W1'(NUM_REQ)) begin
                scan_idx = scan_idx - ID_W1'(NUM_REQ);
            end
            if (req[scan_idx[ID_W-1:0]]) begin
                sel_id    = scan_idx[ID_W-1:0];
                sel_found = 1'b1;
            end
        end
    end

    // Edge detect lets an acb that parks done high between operations still be used.
    assign done_rise = acb_done & ~done_q;

`ifdef ACB_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] wait_cnt;
    logic             abort_q;
    logic             timed_out;

    assign acb_rst = rst | abort_q;
`else
    assign acb_rst = rst;
    assign res_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= IDLE;
            ptr               <= '0;
            id                <= '0;
            done_q            <= 1'b0;
            gnt               <= '0;
            res               <= '0;
            res_valid         <= '0;
            busy              <= 1'b0;
            acb_enable        <= 1'b0;
            acb_configuration <= 1'b0;
            acb_a             <= '0;
            acb_b             <= '0;
`ifdef ACB_ARB_TIMEOUT_EN
            wait_cnt          <= '0;
            abort_q           <= 1'b0;
            timed_out         <= 1'b0;
            res_err           <= 1'b0;
`endif
        end else begin
            done_q     <= acb_done;
            gnt        <= '0;
            res_valid  <= '0;
            acb_enable <= 1'b0;
`ifdef ACB_ARB_TIMEOUT_EN
            abort_q    <= 1'b0;
            res_err    <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (sel_found) begin
                        id                <= sel_id;
                        acb_a             <= req_a[sel_id*WIDTH +: WIDTH];
                        acb_b             <= req_b[sel_id*WIDTH +: WIDTH];
                        acb_configuration <= req_op[sel_id];
                        gnt               <= ONE_HOT0 << sel_id;
                        acb_enable        <= 1'b1;
                        busy              <= 1'b1;
                        state             <= ISSUE;
                    end
                end
                ISSUE: begin
`ifdef ACB_ARB_TIMEOUT_EN
                    wait_cnt  <= '0;
                    timed_out <= 1'b0;
`endif
                    state <= WAIT;
                end
                WAIT: begin
                    if (done_rise) begin
                        res   <= acb_c;
                        state <= RESP;
                    end
`ifdef ACB_ARB_TIMEOUT_EN
                    else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
                        res       <= '0;
                        abort_q   <= 1'b1;
                        timed_out <= 1'b1;
                        state     <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
`endif
                end
                RESP: begin
                    res_valid <= ONE_HOT0 << id;
                    ptr       <= (id == ID_W'(NUM_REQ - 1)) ? '0 : id + ID_W'(1);
                    busy      <= 1'b0;
                    state     <= IDLE;
`ifdef ACB_ARB_TIMEOUT_EN
                    res_err   <= timed_out;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_acb_arbiter.sv
// tb/tb_acb_arbiter.sv - randomized self-checking bench for acb_arbiter with a GF(2^163) acb stub
// Watchdog scenario runs only when ACB_ARB_TIMEOUT_EN is defined.
module tb_acb_arbiter;
    localparam int WIDTH   = 163;
    localparam int NUM_REQ = 4;
    localparam int TIMEOUT = 16;
`ifdef ACB_ARB_TIMEOUT_EN
    localparam int LONG_LAT = 12;
    localparam int MAX_LAT  = 12;
`else
    localparam int LONG_LAT = 163;
    localparam int MAX_LAT  = 40;
`endif
    localparam logic [WIDTH-1:0] POLY_LOW = 163'hC9;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ-1:0]       req_op;
    logic [NUM_REQ*WIDTH-1:0] req_a;
    logic [NUM_REQ*WIDTH-1:0] req_b;
    logic [NUM_REQ-1:0]       gnt;
    logic [WIDTH-1:0]         res;
    logic [NUM_REQ-1:0]       res_valid;
    logic                     res_err;
    logic                     busy;
    logic                     acb_rst;
    logic                     acb_enable;
    logic                     acb_configuration;
    logic [WIDTH-1:0]         acb_a;
    logic [WIDTH-1:0]         acb_b;
    logic [WIDTH-1:0]         acb_c;
    logic                     acb_done;

    acb_arbiter #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .req(req), .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .gnt(gnt), .res(res), .res_valid(res_valid), .res_err(res_err), .busy(busy),
        .acb_rst(acb_rst), .acb_enable(acb_enable), .acb_configuration(acb_configuration),
        .acb_a(acb_a), .acb_b(acb_b), .acb_c(acb_c), .acb_done(acb_done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int ptr_m    = 0;
    int exp_id;
    int rr_order [5] = '{0, 1, 2, 3, 0};
    int alt_order [3] = '{1, 3, 1};
    logic [NUM_REQ-1:0] mask;
    logic [WIDTH-1:0] op_a [NUM_REQ];
    logic [WIDTH-1:0] op_b [NUM_REQ];
    logic             op_m [NUM_REQ];

    task automatic check(input string tag, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [WIDTH-1:0] gf_mul(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] r;
        logic [WIDTH-1:0] x;
        r = '0;
        x = a;
        for (int i = 0; i < WIDTH; i++) begin
            if (b[i]) r = r ^ x;
            x = x[WIDTH-1] ? ((x << 1) ^ POLY_LOW) : (x << 1);
        end
        return r;
    endfunction

    function automatic logic [WIDTH-1:0] acb_model(input logic op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] p;
        p = gf_mul(a, b);
        return op ? p : gf_mul(p, p);
    endfunction

    function automatic logic [WIDTH-1:0] rand_fe();
        logic [191:0] t;
        t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        return t[WIDTH-1:0];
    endfunction

    function automatic logic [NUM_REQ-1:0] onehot(input int i);
        logic [NUM_REQ-1:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // Round-robin rule: first pending requester at or after the model pointer, wrapping.
    function automatic int model_pick(input logic [NUM_REQ-1:0] pend);
        for (int k = 0; k < NUM_REQ; k++) begin
            if (pend[(ptr_m + k) % NUM_REQ]) return (ptr_m + k) % NUM_REQ;
        end
        return 0;
    endfunction

    task automatic set_req(input int i, input logic op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        op_a[i] = a;
        op_b[i] = b;
        op_m[i] = op;
        req_a[i*WIDTH +: WIDTH] = a;
        req_b[i*WIDTH +: WIDTH] = b;
        req_op[i] = op;
        req[i] = 1'b1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        acb_done = 1'b0;
        req = '0;
        @(negedge clk);
        rst = 1'b0;
        ptr_m = 0;
    endtask

    // One grant/compute/response round; called at a negedge with the FSM idle or about to be.
    task automatic serve(input int eid, input int lat, input bit reraise, input bit level_in, input bit hold_done);
        int waited;
        int gid;
        logic [WIDTH-1:0] exp_res;
        waited = 0;
        gid = eid;
        do begin
            @(negedge clk);
            waited++;
        end while (gnt == '0 && waited < 20);
        check("gnt_latency", WIDTH'(waited), WIDTH'(1));
        check("gnt", WIDTH'(gnt), WIDTH'(onehot(eid)));
        check("acb_enable", WIDTH'(acb_enable), WIDTH'(1'b1));
        check("acb_a", acb_a, op_a[eid]);
        check("acb_b", acb_b, op_b[eid]);
        check("acb_cfg", WIDTH'(acb_configuration), WIDTH'(op_m[eid]));
        for (int i = 0; i < NUM_REQ; i++) if (gnt[i]) gid = i;
        req[gid] = 1'b0;
        exp_res = acb_model(op_m[eid], op_a[eid], op_b[eid]);
        for (int k = 0; k < lat; k++) begin
            @(negedge clk);
            if (k == 0 && reraise) req[gid] = 1'b1;
            if (level_in && k == lat - 2) acb_done = 1'b0;
            check("no_early_resp", WIDTH'({busy, res_valid, acb_enable}), WIDTH'({1'b1, {NUM_REQ{1'b0}}, 1'b0}));
        end
        acb_c = acb_model(acb_configuration, acb_a, acb_b);
        acb_done = 1'b1;
        @(negedge clk);
        if (!hold_done) acb_done = 1'b0;
        check("res_valid_early", WIDTH'(res_valid), '0);
        @(negedge clk);
        check("res_valid", WIDTH'(res_valid), WIDTH'(onehot(eid)));
        check("res", res, exp_res);
        check("res_err", WIDTH'(res_err), '0);
        check("busy_after", WIDTH'(busy), '0);
        ptr_m = (eid + 1) % NUM_REQ;
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "bench stalled");
    end

    initial begin
        rst = 1'b1;
        req = '0;
        req_op = '0;
        req_a = '0;
        req_b = '0;
        acb_c = '0;
        acb_done = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_gnt", WIDTH'(gnt), '0);
        check("rst_res", res, '0);
        check("rst_res_valid", WIDTH'(res_valid), '0);
        check("rst_misc", WIDTH'({res_err, busy, acb_enable, acb_configuration}), '0);
        check("rst_acb_a", acb_a, '0);
        check("rst_acb_b", acb_b, '0);
        check("rst_acb_rst", WIDTH'(acb_rst), WIDTH'(1'b1));
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("idle_quiet", WIDTH'({gnt, busy, acb_rst}), '0);
        end

        set_req(0, 1'b1, 163'd2, 163'd3);
        serve(0, LONG_LAT, 1'b0, 1'b0, 1'b0);
        check("mult_res6", res, 163'd6);

        set_req(2, 1'b0, 163'd2, 163'd1);
        serve(2, 10, 1'b0, 1'b0, 1'b0);
        check("square_res4", res, 163'd4);

        do_reset();
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'($urandom_range(0, 1)), rand_fe(), rand_fe());
        for (int n = 0; n < 5; n++) serve(rr_order[n], int'($urandom_range(2, 6)), 1'b1, 1'b0, 1'b0);
        req = '0;
        @(negedge clk);
        @(negedge clk);
        check("rr_cleared", WIDTH'({gnt, busy}), '0);

        set_req(1, 1'b1, rand_fe(), rand_fe());
        set_req(3, 1'b0, rand_fe(), rand_fe());
        for (int n = 0; n < 3; n++) serve(alt_order[n], int'($urandom_range(2, 6)), 1'b1, 1'b0, 1'b0);
        req = '0;
        @(negedge clk);

        for (int it = 0; it < 25; it++) begin
            mask = NUM_REQ'($urandom_range(1, (1 << NUM_REQ) - 1));
            for (int i = 0; i < NUM_REQ; i++) begin
                if (mask[i]) set_req(i, 1'($urandom_range(0, 1)), rand_fe(), rand_fe());
            end
            for (int n = 0; n < NUM_REQ && req != '0; n++) begin
                exp_id = model_pick(req);
                serve(exp_id, int'($urandom_range(1, MAX_LAT)), 1'b0, 1'b0, 1'b0);
            end
        end

        set_req(0, 1'b1, rand_fe(), rand_fe());
        serve(model_pick(req), 6, 1'b0, 1'b0, 1'b1);
        set_req(1, 1'b0, rand_fe(), rand_fe());
        serve(model_pick(req), 8, 1'b0, 1'b1, 1'b0);

        set_req(1, 1'b1, rand_fe(), rand_fe());
        serve(model_pick(req), 4, 1'b0, 1'b0, 1'b0);
        set_req(2, 1'b1, rand_fe(), rand_fe());
        exp_id = model_pick(req);
        @(negedge clk);
        check("abort_gnt", WIDTH'(gnt), WIDTH'(onehot(exp_id)));
        req[2] = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_acb_rst", WIDTH'(acb_rst), WIDTH'(1'b1));
        @(negedge clk);
        rst = 1'b0;
        ptr_m = 0;
        check("abort_idle", WIDTH'({busy, gnt, res_valid}), '0);
        acb_done = 1'b1;
        @(negedge clk);
        acb_done = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("abort_quiet", WIDTH'({busy, gnt, res_valid}), '0);
        end
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b1, rand_fe(), rand_fe());
        serve(0, 5, 1'b0, 1'b0, 1'b0);
        req = '0;
        @(negedge clk);

`ifdef ACB_ARB_TIMEOUT_EN
        set_req(3, 1'b1, rand_fe(), rand_fe());
        @(negedge clk);
        check("wd_gnt", WIDTH'(gnt), WIDTH'(onehot(3)));
        req[3] = 1'b0;
        for (int k = 1; k <= TIMEOUT; k++) begin
            @(negedge clk);
            check("wd_quiet", WIDTH'({acb_rst, res_valid, res_err}), '0);
        end
        @(negedge clk);
        check("wd_acb_rst", WIDTH'({acb_rst, res_valid}), WIDTH'({1'b1, {NUM_REQ{1'b0}}}));
        @(negedge clk);
        check("wd_res_valid", WIDTH'(res_valid), WIDTH'(onehot(3)));
        check("wd_res_err", WIDTH'(res_err), WIDTH'(1'b1));
        check("wd_res_zero", res, '0);
        check("wd_acb_rst_off", WIDTH'(acb_rst), '0);
        ptr_m = 0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
